// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the
// round-robin mux arbiter and its mux instance.
package arb_pkg;

    localparam int ARB_N_REQ     = 16;
    localparam int ARB_SEL_W     = 4;
    localparam int ARB_MAX_BEATS = 8;
    localparam int ARB_CNT_W     = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin pick: first set request strictly
// after ptr, wrapping, so ptr itself is last.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N_REQ,
    parameter int W = ARB_SEL_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] winner
);

    int idx;

    // Scan farthest-first so the nearest hit wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                any    = 1'b1;
                winner = W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared 16:1 mux,
// holding each grant for a bounded burst.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ     = ARB_N_REQ,
    parameter int SEL_W     = ARB_SEL_W,
    parameter int MAX_BEATS = ARB_MAX_BEATS,
    parameter int CNT_W     = ARB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic             beat
);

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(MAX_BEATS - 1);
    localparam logic [N_REQ-1:0] ONE =
        N_REQ'(1);

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [N_REQ-1:0] grant_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             any;
    logic [SEL_W-1:0] win;
    logic             granted;
    logic             rel;

    rr_pick #(
        .N (N_REQ),
        .W (SEL_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (win)
    );

    // Handshake and release conditions for the owner.
    always_comb begin
        granted   = (state == ST_GRANT);
        out_valid = granted && req[sel];
        beat      = out_valid && out_ready;
        rel       = granted &&
                    (!req[sel] ||
                     (beat && (last[sel] ||
                               cnt == CNT_LAST)));
    end

    // Next-state: arbitrate, count beats, release.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        grant_n = grant;
        ptr_n   = ptr;
        cnt_n   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (any) begin
                    state_n = ST_GRANT;
                    sel_n   = win;
                    grant_n = ONE << win;
                    ptr_n   = win;
                    cnt_n   = '0;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    if (any) begin
                        sel_n   = win;
                        grant_n = ONE << win;
                        ptr_n   = win;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_IDLE;
                        grant_n = '0;
                    end
                end else if (beat) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    // State register; pointer resets so 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
            grant <= '0;
            ptr   <= SEL_W'(N_REQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            grant <= grant_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with an
// expectation queue checked each cycle.
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] last;
    logic        out_ready;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        out_valid;
    logic        beat;

    typedef struct packed {
        logic [15:0] g;
        logic [3:0]  s;
        logic        v;
        logic        b;
    } exp_t;

    exp_t q[$];
    int   vectors;
    int   miscompares;

    rr_mux_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .beat      (beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [15:0] g,
                        input logic [3:0] s,
                        input logic v,
                        input logic b);
        exp_t e;
        e.g = g;
        e.s = s;
        e.v = v;
        e.b = b;
        q.push_back(e);
    endtask

    task automatic chk(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: queue empty", tag);
        end else begin
            e = q.pop_front();
            vectors += 4;
            assert (grant === e.g) else begin
                miscompares++;
                $error("FAIL %s grant got %h exp %h",
                       tag, grant, e.g);
            end
            assert (sel === e.s) else begin
                miscompares++;
                $error("FAIL %s sel got %0d exp %0d",
                       tag, sel, e.s);
            end
            assert (out_valid === e.v) else begin
                miscompares++;
                $error("FAIL %s valid got %b exp %b",
                       tag, out_valid, e.v);
            end
            assert (beat === e.b) else begin
                miscompares++;
                $error("FAIL %s beat got %b exp %b",
                       tag, beat, e.b);
            end
        end
    endtask

    // Drive one cycle, check at negedge, end at posedge+1.
    task automatic cyc(input string tag,
                       input logic [15:0] r,
                       input logic [15:0] l,
                       input logic rdy,
                       input logic [15:0] g,
                       input logic [3:0] s,
                       input logic v,
                       input logic b);
        req       = r;
        last      = l;
        out_ready = rdy;
        push(g, s, v, b);
        @(negedge clk);
        chk(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        last = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = '0;
        last        = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("rst_state", 16'h0, 16'h0, 1'b0,
            16'h0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single requester, single-beat burst.
        cyc("t1_idle", 16'h1, 16'h1, 1'b1,
            16'h0, 4'd0, 1'b0, 1'b0);
        cyc("t1_beat", 16'h1, 16'h1, 1'b1,
            16'h1, 4'd0, 1'b1, 1'b1);
        cyc("t1_drop", 16'h0, 16'h0, 1'b1,
            16'h1, 4'd0, 1'b0, 1'b0);
        cyc("t1_end", 16'h0, 16'h0, 1'b1,
            16'h0, 4'd0, 1'b0, 1'b0);

        // Everyone requesting: strict rotation.
        do_reset();
        cyc("t2_idle", 16'hFFFF, 16'hFFFF, 1'b1,
            16'h0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 17; k++) begin
            cyc("t2_rot", 16'hFFFF, 16'hFFFF, 1'b1,
                16'h1 << (k % 16), 4'(k % 16),
                1'b1, 1'b1);
        end
        cyc("t2_drop", 16'h0, 16'h0, 1'b1,
            16'h2, 4'd1, 1'b0, 1'b0);
        cyc("t2_end", 16'h0, 16'h0, 1'b1,
            16'h0, 4'd1, 1'b0, 1'b0);

        // Forced release after 8 beats, count restarts.
        cyc("t3_idle", 16'h10, 16'h0, 1'b1,
            16'h0, 4'd1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc("t3_b1", 16'h10, 16'h0, 1'b1,
                16'h10, 4'd4, 1'b1, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            cyc("t3_b2", 16'h30, 16'h0, 1'b1,
                16'h10, 4'd4, 1'b1, 1'b1);
        end
        cyc("t3_to5", 16'h30, 16'h0, 1'b1,
            16'h20, 4'd5, 1'b1, 1'b1);
        cyc("t3_drop", 16'h0, 16'h0, 1'b1,
            16'h20, 4'd5, 1'b0, 1'b0);
        cyc("t3_end", 16'h0, 16'h0, 1'b1,
            16'h0, 4'd5, 1'b0, 1'b0);

        // Backpressure holds grant and count.
        cyc("t4_idle", 16'h24, 16'h0, 1'b0,
            16'h0, 4'd5, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc("t4_hold", 16'h24, 16'h0, 1'b0,
                16'h4, 4'd2, 1'b1, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            cyc("t4_beat", 16'h24, 16'h0, 1'b1,
                16'h4, 4'd2, 1'b1, 1'b1);
        end
        cyc("t4_to5", 16'h24, 16'h0, 1'b1,
            16'h20, 4'd5, 1'b1, 1'b1);

        // Owner 5 withdraws mid-burst, 9 takes over.
        cyc("t5_b", 16'h220, 16'h0, 1'b1,
            16'h20, 4'd5, 1'b1, 1'b1);
        cyc("t5_wd", 16'h200, 16'h0, 1'b1,
            16'h20, 4'd5, 1'b0, 1'b0);
        cyc("t5_to9", 16'h200, 16'h200, 1'b1,
            16'h200, 4'd9, 1'b1, 1'b1);
        cyc("t5_drop", 16'h0, 16'h0, 1'b1,
            16'h200, 4'd9, 1'b0, 1'b0);
        cyc("t5_end", 16'h0, 16'h0, 1'b1,
            16'h0, 4'd9, 1'b0, 1'b0);

        // Async reset mid-grant with count at 3.
        cyc("t6_idle", 16'h80, 16'h0, 1'b1,
            16'h0, 4'd9, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc("t6_b", 16'h80, 16'h0, 1'b1,
                16'h80, 4'd7, 1'b1, 1'b1);
        end
        rst = 1'b1;
        push(16'h0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("t6_idle2", 16'h80, 16'h0, 1'b1,
            16'h0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc("t6_b2", 16'h81, 16'h0, 1'b1,
                16'h80, 4'd7, 1'b1, 1'b1);
        end
        cyc("t6_to0", 16'h81, 16'h0, 1'b1,
            16'h1, 4'd0, 1'b1, 1'b1);
        cyc("t6_drop", 16'h0, 16'h0, 1'b1,
            16'h1, 4'd0, 1'b0, 1'b0);
        cyc("t6_end", 16'h0, 16'h0, 1'b1,
            16'h0, 4'd0, 1'b0, 1'b0);

        if (q.size() != 0) begin
            miscompares++;
            $error("FAIL leftover %0d entries",
                   q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
